cfg_shift_sequencer: RTL and testbench

- Wishbone slave that sequences FPGA column configuration.
- Accepts 32-bit bitstream words from the management core and buffers them in a small FIFO.
- Serialises the words onto one column's config shift chain, one bit per clock, gated by cen.
- After exactly BITS_TOTAL bits it asserts set_out, which stays high, to latch the column. One instance per column chain, placed inside the user project wrapper.

---
 rtl/cfg_shift_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_cfg_shift_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_shift_sequencer.sv
// Wishbone-fed config sequencer: buffers bitstream words, shifts one column chain LSB first, then latches.
// Latency: bus ack one cycle after the request; first bit leaves the cycle after the first DATA push.
// Backpressure: a DATA write to a full FIFO is held without ack until the head word finishes shifting.

// Generic single-clock word FIFO with synchronous flush.
// Latency: a pushed word is visible on rd_dat the cycle after the push.
// Backpressure: a push while full is only taken if a pop happens in the same cycle.
module fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wr_vld,
  input  logic [WIDTH-1:0]           wr_dat,
  input  logic                       rd_rdy,
  output logic [WIDTH-1:0]           rd_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    cnt;
  logic             do_wr;
  logic             do_rd;

  assign full   = (cnt == LW'(DEPTH));
  assign empty  = (cnt == '0);
  assign level  = cnt;
  assign rd_dat = mem[rd_ptr];
  assign do_wr  = wr_vld && (!full || rd_rdy);
  assign do_rd  = rd_rdy && !empty;

  // Pointer and occupancy bookkeeping; flush drops every stored word.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (do_wr && !do_rd)      cnt <= cnt + 1'b1;
      else if (!do_wr && do_rd) cnt <= cnt - 1'b1;
    end
  end

  // Storage array; contents need no reset because occupancy guards reads.
  always_ff @(posedge clk) begin
    if (do_wr && !flush) mem[wr_ptr] <= wr_dat;
  end
endmodule

module cfg_shift_sequencer #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          BITS_TOTAL = 1024,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        cen,
  output logic        shift_out,
  output logic        set_out,
  output logic        busy
);
  localparam int            CW       = $clog2(BITS_TOTAL + 1);
  localparam int            LW       = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] BITS_END = CW'(BITS_TOTAL);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_LATCH, ST_DONE} state_t;
  state_t state_q, state_d;

  logic          ack_q;
  logic [31:0]   rdat_q;
  logic          err_q;
  logic          set_q;
  logic [CW-1:0] bit_cnt_q;
  logic [4:0]    bit_idx_q;

  logic [31:0]   fifo_dat;
  logic          fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_flush;
  logic [LW-1:0] fifo_level;

  logic req, sel_data, sel_ctrl, sel_stat, data_wr, ctrl_wr;
  logic chain_end, shift_en, stall, accept, discard;
  logic do_start, do_abort, start_go;
  logic [31:0] cnt_ext, lvl_ext, status;
  logic unused_adr;

  assign unused_adr = &{1'b0, wbs_adr_i[1:0]};

  // Bus decode: only the upper 28 address bits select this block.
  assign req      = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign sel_data = (wbs_adr_i[3:2] == 2'd0);
  assign sel_ctrl = (wbs_adr_i[3:2] == 2'd1);
  assign sel_stat = (wbs_adr_i[3:2] == 2'd2);
  assign data_wr  = req && wbs_we_i && sel_data;

  // The head word stays in the FIFO while it shifts; it pops on its bit 31.
  assign chain_end = (state_q == ST_SHIFT) && (bit_cnt_q == BITS_END);
  assign shift_en  = (state_q == ST_SHIFT) && !chain_end && !fifo_empty;
  assign fifo_pop  = shift_en && (bit_idx_q == 5'd31);

  // A full FIFO holds off the ack; at chain end the write is taken and flushed.
  assign stall      = data_wr && (state_q == ST_SHIFT) && fifo_full && !fifo_pop && !chain_end;
  assign accept     = req && !ack_q && !stall;
  assign fifo_push  = accept && data_wr && (state_q == ST_SHIFT);
  assign discard    = accept && data_wr && (state_q != ST_SHIFT);
  assign ctrl_wr    = accept && wbs_we_i && sel_ctrl;
  assign do_abort   = ctrl_wr && wbs_dat_i[1];
  assign do_start   = ctrl_wr && wbs_dat_i[0] && !wbs_dat_i[1];
  assign start_go   = do_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign fifo_flush = do_abort || chain_end;

  fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .flush  (fifo_flush),
    .wr_vld (fifo_push),
    .wr_dat (wbs_dat_i),
    .rd_rdy (fifo_pop),
    .rd_dat (fifo_dat),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  assign cnt_ext = 32'(bit_cnt_q);
  assign lvl_ext = 32'(fifo_level);
  assign status  = {cnt_ext[15:0], lvl_ext[7:0], 3'b000, err_q, fifo_empty, fifo_full, busy, set_q};

  assign cen       = shift_en;
  assign shift_out = shift_en && fifo_dat[bit_idx_q];
  assign set_out   = set_q;
  assign busy      = (state_q == ST_SHIFT) || (state_q == ST_LATCH);
  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rdat_q;

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; ABORT overrides every transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_go) state_d = ST_SHIFT;
      ST_SHIFT: if (chain_end) state_d = ST_LATCH;
      ST_LATCH: state_d = ST_DONE;
      ST_DONE:  if (start_go) state_d = ST_SHIFT;
      default:  state_d = ST_IDLE;
    endcase
    if (do_abort) state_d = ST_IDLE;
  end

  // Bus response: one-cycle ack, forced low the cycle after, STATUS data with it.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q  <= 1'b0;
      rdat_q <= '0;
    end else begin
      ack_q  <= accept;
      rdat_q <= (accept && !wbs_we_i && sel_stat) ? status : '0;
    end
  end

  // Sequencer bookkeeping: bit counter, bit index in head word, sticky err, latch level.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      err_q     <= 1'b0;
      set_q     <= 1'b0;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
    end else begin
      if (start_go)     err_q <= 1'b0;
      else if (discard) err_q <= 1'b1;

      if (start_go)      bit_cnt_q <= '0;
      else if (shift_en) bit_cnt_q <= bit_cnt_q + 1'b1;

      if (fifo_flush || start_go) bit_idx_q <= '0;
      else if (shift_en)          bit_idx_q <= bit_idx_q + 1'b1;

      if (do_abort || start_go)      set_q <= 1'b0;
      else if (state_q == ST_LATCH)  set_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_cfg_shift_sequencer.sv
// Directed bench for cfg_shift_sequencer: two instances on one bus at different bases.
// Instance A: 40-bit chain; instance B: 192-bit chain (six full words).
// Shifted bits are captured on the falling edge whenever cen is high.
module tb_cfg_shift_sequencer;
  localparam logic [31:0] A_BASE = 32'h3000_0000;
  localparam logic [31:0] B_BASE = 32'h3000_0010;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        cyc, stb, we;
  logic [31:0] adr, wdat;
  logic        ack_a, ack_b;
  logic [31:0] dat_a, dat_b;
  logic        cen_a, so_a, set_a, busy_a;
  logic        cen_b, so_b, set_b, busy_b;

  int checks = 0;
  int errors = 0;
  bit cap_a[$];
  bit cap_b[$];

  always #5 wb_clk_i = ~wb_clk_i;

  cfg_shift_sequencer #(.BASE_ADDR(A_BASE), .BITS_TOTAL(40), .FIFO_DEPTH(4)) u_dut_a (
    .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i),
    .wbs_cyc_i (cyc), .wbs_stb_i (stb), .wbs_we_i (we),
    .wbs_adr_i (adr), .wbs_dat_i (wdat),
    .wbs_ack_o (ack_a), .wbs_dat_o (dat_a),
    .cen (cen_a), .shift_out (so_a), .set_out (set_a), .busy (busy_a)
  );

  cfg_shift_sequencer #(.BASE_ADDR(B_BASE), .BITS_TOTAL(192), .FIFO_DEPTH(4)) u_dut_b (
    .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i),
    .wbs_cyc_i (cyc), .wbs_stb_i (stb), .wbs_we_i (we),
    .wbs_adr_i (adr), .wbs_dat_i (wdat),
    .wbs_ack_o (ack_b), .wbs_dat_o (dat_b),
    .cen (cen_b), .shift_out (so_b), .set_out (set_b), .busy (busy_b)
  );

  // Capture every shifted bit of each chain.
  always @(negedge wb_clk_i) begin
    if (cen_a) cap_a.push_back(so_a);
    if (cen_b) cap_b.push_back(so_b);
  end

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wb_xfer(input logic [31:0] a, input bit w, input logic [31:0] d,
                         input bit exp_ack, input int limit,
                         output logic [31:0] rd, output int n);
    bit acked = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
    n = 0; rd = '0;
    while (!acked && n < limit) begin
      @(negedge wb_clk_i);
      n++;
      if (ack_a || ack_b) begin
        acked = 1'b1;
        rd = ack_a ? dat_a : dat_b;
      end
    end
    chk($sformatf("ack_%h", a), 192'(acked), 192'(exp_ack));
    @(posedge wb_clk_i); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd;
    int n;
    wb_xfer(a, 1'b1, d, 1'b1, 200, rd, n);
  endtask

  task automatic wr_n(input logic [31:0] a, input logic [31:0] d, output int n);
    logic [31:0] rd;
    wb_xfer(a, 1'b1, d, 1'b1, 200, rd, n);
  endtask

  task automatic rd_reg(input logic [31:0] a, output logic [31:0] d);
    int n;
    wb_xfer(a, 1'b0, 32'h0, 1'b1, 20, d, n);
  endtask

  // Wait for set_out; the cycle just before it must be LATCH (busy, no cen).
  task automatic wait_set(input bit sel_b, input int limit);
    bit prev_busy = 1'b0;
    bit prev_cen = 1'b1;
    bit seen = 1'b0;
    int n = 0;
    while (!seen && n < limit) begin
      @(negedge wb_clk_i);
      n++;
      if (sel_b ? set_b : set_a) seen = 1'b1;
      else begin
        prev_busy = sel_b ? busy_b : busy_a;
        prev_cen  = sel_b ? cen_b : cen_a;
      end
    end
    chk("set_seen", 192'(seen), 192'(1'b1));
    chk("latch_cycle", 192'({prev_busy, prev_cen}), 192'(2'b10));
    chk("done_busy", 192'(sel_b ? busy_b : busy_a), 192'(1'b0));
  endtask

  function automatic logic [191:0] pack(input bit sel_b);
    logic [191:0] v = '0;
    int sz = sel_b ? cap_b.size() : cap_a.size();
    for (int i = 0; i < sz && i < 192; i++) v[i] = sel_b ? cap_b[i] : cap_a[i];
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    logic [191:0] v;
    int n;
    logic [31:0] ws [6];
    int exp_n [6];
    ws    = '{32'h0000_0001, 32'h8000_0000, 32'hDEAD_BEEF, 32'h1234_5678, 32'hF0F0_0F0F, 32'h5555_AAAA};
    exp_n = '{2, 2, 2, 2, 26, 32};

    cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0; wb_rst_i = 1'b1;
    repeat (3) @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    chk("rst_out_a", 192'({ack_a, dat_a, cen_a, so_a, set_a, busy_a}), '0);
    chk("rst_out_b", 192'({ack_b, dat_b, cen_b, so_b, set_b, busy_b}), '0);
    rd_reg(A_BASE + 32'h8, d);
    chk("rst_status_a", 192'(d), 192'(32'h0000_0008));

    // Two words on a 40-bit chain: 0x5 fully, then the low 8 bits of 0xFF.
    cap_a.delete();
    wr(A_BASE + 32'h4, 32'h1);
    wr(A_BASE, 32'h0000_0005);
    wr(A_BASE, 32'h0000_00FF);
    wait_set(1'b0, 200);
    chk("t1_nbits", 192'(cap_a.size()), 192'(40));
    chk("t1_bits", pack(1'b0), 192'hFF_0000_0005);
    repeat (4) @(negedge wb_clk_i);
    rd_reg(A_BASE + 32'h8, d);
    chk("t1_status", 192'(d), 192'(32'h0028_0009));

    // Write-only registers read back zero; a foreign address gets no ack.
    rd_reg(A_BASE, d);
    chk("rd_data_zero", 192'(d), '0);
    rd_reg(A_BASE + 32'h4, d);
    chk("rd_ctrl_zero", 192'(d), '0);
    wb_xfer(32'h3000_0100, 1'b1, 32'h1, 1'b0, 8, d, n);
    chk("unmapped_noeffect", 192'(set_a), 192'(1'b1));

    // Restart from DONE; the third word must never reach the chain.
    cap_a.delete();
    wr(A_BASE + 32'h4, 32'h1);
    chk("t3_set_clr", 192'(set_a), '0);
    wr(A_BASE, 32'hAAAA_AAAA);
    wr(A_BASE, 32'h0000_0000);
    wr(A_BASE, 32'hFFFF_FFFF);
    wait_set(1'b0, 200);
    chk("t3_nbits", 192'(cap_a.size()), 192'(40));
    chk("t3_bits", pack(1'b0), 192'h00_AAAA_AAAA);
    rd_reg(A_BASE + 32'h8, d);
    chk("t3_status", 192'(d), 192'(32'h0028_0009));

    // DATA write while idle is acked, dropped and flags err; START clears err.
    cap_b.delete();
    wr(B_BASE, 32'h0000_1234);
    repeat (3) @(negedge wb_clk_i);
    chk("idle_no_cen", 192'(cap_b.size()), '0);
    rd_reg(B_BASE + 32'h8, d);
    chk("idle_err_status", 192'(d), 192'(32'h0000_0018));
    wr(B_BASE + 32'h4, 32'h1);
    rd_reg(B_BASE + 32'h8, d);
    chk("start_err_clr", 192'(d), 192'(32'h0000_000A));

    // Six back-to-back words into a 4-deep FIFO: writes 5 and 6 wait for pops.
    for (int k = 0; k < 6; k++) begin
      wr_n(B_BASE, ws[k], n);
      chk($sformatf("t2_ack_cycles_%0d", k), 192'(n), 192'(exp_n[k]));
    end
    wait_set(1'b1, 400);
    chk("t2_nbits", 192'(cap_b.size()), 192'(192));
    v = pack(1'b1);
    for (int k = 0; k < 6; k++) chk($sformatf("t2_word_%0d", k), 192'(v[32*k +: 32]), 192'(ws[k]));
    rd_reg(B_BASE + 32'h8, d);
    chk("t2_status", 192'(d), 192'(32'h00C0_0009));

    // ABORT (with START also set) after exactly 10 bits.
    cap_a.delete();
    wr(A_BASE + 32'h4, 32'h1);
    wr(A_BASE, 32'hFFFF_FFFF);
    repeat (8) @(posedge wb_clk_i); #1;
    wr(A_BASE + 32'h4, 32'h3);
    chk("abort_out", 192'({cen_a, set_a, busy_a}), '0);
    chk("abort_nbits", 192'(cap_a.size()), 192'(10));
    rd_reg(A_BASE + 32'h8, d);
    chk("abort_status", 192'(d), 192'(32'h000A_0008));

    // Reset in the middle of a word, then a clean run from bit 0.
    wr(A_BASE + 32'h4, 32'h1);
    wr(A_BASE, 32'h0000_00F0);
    repeat (5) @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    chk("rst_mid_out", 192'({ack_a, dat_a, cen_a, so_a, set_a, busy_a}), '0);
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0;
    rd_reg(A_BASE + 32'h8, d);
    chk("rst_mid_status", 192'(d), 192'(32'h0000_0008));
    cap_a.delete();
    wr(A_BASE + 32'h4, 32'h1);
    wr(A_BASE, 32'h0000_0003);
    wr(A_BASE, 32'h0000_0000);
    wait_set(1'b0, 200);
    chk("rst_rerun_nbits", 192'(cap_a.size()), 192'(40));
    chk("rst_rerun_bits", pack(1'b0), 192'h00_0000_0003);
    rd_reg(A_BASE + 32'h8, d);
    chk("rst_rerun_status", 192'(d), 192'(32'h0028_0009));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
